// File: rtl/pc_fetch_pkg.sv
// Shared widths, PC step and FSM state encoding for the PC fetch unit.
package pc_fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request bus plus the valid/ready output toward decode.
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    // imem: imem_req/imem_addr stay asserted and stable until the single-cycle
    // imem_ack, which carries imem_rdata. Decode side: a word moves on any
    // cycle with out_valid && out_ready; out_instr/out_pc hold while stalled.
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_ack, imem_rdata, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_ack, imem_rdata, out_ready
    );

endinterface

// File: rtl/pc_fetch_unit_incr.sv
// Sequential-PC adder: pc + PC_STEP, modulo 2^PC_W (carry dropped).
module pc_incrementer
    import pc_fetch_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_next_o
);

    assign pc_next_o = pc_i + PC_W'(PC_STEP);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch unit: IDLE/REQ/HOLD fetch FSM with branch redirect and flush.
// Optional macro PC_ALIGN_CHECK_EN: misaligned branches are ignored and flagged.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    pc_fetch_if.master      bus,
    output logic            align_err,
    output state_e          state_o
);

    localparam logic [PC_W-1:0] RST_PC = RESET_PC & ~PC_W'(3);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic [PC_W-1:0]    opc_q, opc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               req_q, req_d;
    logic               flush_q, flush_d;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    br_tgt;
    logic               br_take;

    pc_incrementer u_incr (
        .pc_i      (pc_q),
        .pc_next_o (pc_inc)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic align_err_q;

    assign br_take = branch_valid && (branch_target[1:0] == 2'b00);
    assign br_tgt  = branch_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) align_err_q <= 1'b0;
        else        align_err_q <= branch_valid && (branch_target[1:0] != 2'b00);
    end

    assign align_err = align_err_q;
`else
    assign br_take   = branch_valid;
    assign br_tgt    = branch_target & ~PC_W'(3);
    assign align_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        opc_d   = opc_q;
        instr_d = instr_q;
        flush_d = flush_q;
        case (state_q)
            IDLE: begin
                if (br_take) pc_d = br_tgt;
                if (en)      state_d = REQ;
            end
            REQ: begin
                if (bus.imem_ack) begin
                    if (flush_q || br_take) begin
                        // Redirected while outstanding: drop the word, refetch.
                        flush_d = 1'b0;
                        if (br_take) pc_d = br_tgt;
                        state_d = REQ;
                    end else begin
                        instr_d = bus.imem_rdata;
                        opc_d   = addr_q;
                        state_d = HOLD;
                    end
                end else if (br_take) begin
                    flush_d = 1'b1;
                    pc_d    = br_tgt;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    pc_d    = br_take ? br_tgt : pc_inc;
                    state_d = en ? REQ : IDLE;
                end else if (br_take) begin
                    pc_d    = br_tgt;
                    state_d = en ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Latch the address only when a new request begins so it stays stable.
        if (state_d == REQ && (state_q != REQ || bus.imem_ack)) addr_d = pc_d;
        req_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RST_PC;
            addr_q  <= RST_PC;
            opc_q   <= '0;
            instr_q <= '0;
            req_q   <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            opc_q   <= opc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            flush_q <= flush_d;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = req_q ? addr_q : pc_q;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = opc_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: memory responder, transfer monitor, scenario tasks.
module tb_pc_fetch_unit;
    import pc_fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        bv;
    logic [7:0]  bt;
    logic        align_err;
    state_e      state_dbg;

    int          vec;
    int          err;
    int          mem_lat;
    bit          mem_on;
    int          mem_cnt;
    logic [7:0]  acked_q[$];
    logic [7:0]  xfer_q[$];

    pc_fetch_if bus();

    pc_fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .branch_valid  (bv),
        .branch_target (bt),
        .bus           (bus.master),
        .align_err     (align_err),
        .state_o       (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    function automatic logic [7:0] xq(input int i);
        return (i < xfer_q.size()) ? xfer_q[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] aq(input int i);
        return (i < acked_q.size()) ? acked_q[i] : 8'hxx;
    endfunction

    // ---------------- memory responder ----------------
    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        mem_cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_on) begin
                if (bus.imem_ack) begin
                    bus.imem_ack = 1'b0;
                    mem_cnt      = 0;
                end
                if (bus.imem_req) begin
                    mem_cnt++;
                    if (mem_cnt == mem_lat) begin
                        bus.imem_ack   = 1'b1;
                        bus.imem_rdata = mem_word(bus.imem_addr);
                    end
                end else begin
                    mem_cnt = 0;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.imem_req && bus.imem_ack) acked_q.push_back(bus.imem_addr);
                if (bus.out_valid && bus.out_ready) begin
                    xfer_q.push_back(bus.out_pc);
                    vec++;
                    if (bus.out_instr !== mem_word(bus.out_pc)) begin
                        err++;
                        $display("FAIL xfer_instr: got %h expected %h", bus.out_instr, mem_word(bus.out_pc));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic bit cond_met(input int kind, input int n);
        case (kind)
            0:       return xfer_q.size() >= n;
            1:       return acked_q.size() >= n;
            2:       return bus.out_valid === 1'b1;
            3:       return bus.imem_req === 1'b1;
            default: return (bus.imem_req === 1'b1) && (bus.imem_ack === 1'b1);
        endcase
    endfunction

    task automatic wait_for(input int kind, input int n, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (cond_met(kind, n)) break;
            tick();
        end
        vec++;
        if (!cond_met(kind, n)) begin
            err++;
            $display("FAIL %s: timeout after %0d cycles, condition %0d not reached", name, budget, kind);
        end
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        en            = 1'b0;
        bv            = 1'b0;
        bt            = 8'h00;
        bus.out_ready = 1'b0;
        mem_on        = 1'b1;
        mem_lat       = 2;
        tick();
        tick();
        acked_q.delete();
        xfer_q.delete();
        rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vec += 7;
        if (bus.imem_req !== 1'b0) begin err++; $display("FAIL rst_req: got %b expected 0", bus.imem_req); end
        if (bus.imem_addr !== 8'h00) begin err++; $display("FAIL rst_addr: got %h expected 00", bus.imem_addr); end
        if (bus.out_valid !== 1'b0) begin err++; $display("FAIL rst_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_instr !== 16'h0000) begin err++; $display("FAIL rst_instr: got %h expected 0000", bus.out_instr); end
        if (bus.out_pc !== 8'h00) begin err++; $display("FAIL rst_pc: got %h expected 00", bus.out_pc); end
        if (align_err !== 1'b0) begin err++; $display("FAIL rst_align: got %b expected 0", align_err); end
        if (state_dbg !== IDLE) begin err++; $display("FAIL rst_state: got %0d expected %0d", state_dbg, IDLE); end
    endtask

    task automatic test_sequential();
        logic [7:0] exp_q[$];
        apply_reset();
        exp_q = {8'h00, 8'h04, 8'h08, 8'h0C};
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(0, 4, 80, "seq_wait");
        for (int i = 0; i < 4; i++) begin
            vec += 2;
            if (aq(i) !== exp_q[i]) begin err++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, aq(i), exp_q[i]); end
            if (xq(i) !== exp_q[i]) begin err++; $display("FAIL seq_out_pc[%0d]: got %h expected %h", i, xq(i), exp_q[i]); end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        bv = 1'b1;
        bt = 8'hFC;
        tick();
        bv = 1'b0;
        tick();
        vec += 2;
        if (bus.imem_req !== 1'b0) begin err++; $display("FAIL idle_branch_req: got %b expected 0", bus.imem_req); end
        if (bus.imem_addr !== 8'hFC) begin err++; $display("FAIL idle_branch_pc: got %h expected fc", bus.imem_addr); end
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(0, 2, 40, "wrap_wait");
        vec += 3;
        if (aq(0) !== 8'hFC) begin err++; $display("FAIL wrap_addr0: got %h expected fc", aq(0)); end
        if (aq(1) !== 8'h00) begin err++; $display("FAIL wrap_addr1: got %h expected 00", aq(1)); end
        if (xq(1) !== 8'h00) begin err++; $display("FAIL wrap_out_pc: got %h expected 00", xq(1)); end
    endtask

    task automatic test_stall();
        apply_reset();
        en = 1'b1;
        wait_for(2, 0, 20, "stall_valid");
        for (int k = 0; k < 5; k++) begin
            vec += 4;
            if (bus.out_valid !== 1'b1) begin err++; $display("FAIL stall_valid[%0d]: got %b expected 1", k, bus.out_valid); end
            if (bus.out_pc !== 8'h00) begin err++; $display("FAIL stall_pc[%0d]: got %h expected 00", k, bus.out_pc); end
            if (bus.out_instr !== mem_word(8'h00)) begin err++; $display("FAIL stall_instr[%0d]: got %h expected %h", k, bus.out_instr, mem_word(8'h00)); end
            if (bus.imem_req !== 1'b0) begin err++; $display("FAIL stall_req[%0d]: got %b expected 0", k, bus.imem_req); end
            tick();
        end
        bus.out_ready = 1'b1;
        wait_for(1, 2, 20, "stall_next");
        vec += 2;
        if (aq(1) !== 8'h04) begin err++; $display("FAIL stall_next_addr: got %h expected 04", aq(1)); end
        if (xq(0) !== 8'h00) begin err++; $display("FAIL stall_xfer: got %h expected 00", xq(0)); end
    endtask

    task automatic test_en_low_in_req();
        apply_reset();
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(3, 0, 10, "enlow_req");
        en = 1'b0;
        tick();
        vec++;
        if (bus.imem_req !== 1'b1) begin err++; $display("FAIL enlow_req_held: got %b expected 1", bus.imem_req); end
        wait_for(0, 1, 20, "enlow_xfer");
        for (int k = 0; k < 5; k++) tick();
        vec += 4;
        if (xq(0) !== 8'h00) begin err++; $display("FAIL enlow_out_pc: got %h expected 00", xq(0)); end
        if (bus.imem_req !== 1'b0) begin err++; $display("FAIL enlow_no_req: got %b expected 0", bus.imem_req); end
        if (acked_q.size() != 1) begin err++; $display("FAIL enlow_req_count: got %0d expected 1", acked_q.size()); end
        if (state_dbg !== IDLE) begin err++; $display("FAIL enlow_state: got %0d expected %0d", state_dbg, IDLE); end
    endtask

    task automatic test_branch_in_req();
        apply_reset();
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(3, 0, 10, "breq_req");
        bv = 1'b1;
        bt = 8'h40;
        tick();
        bv = 1'b0;
        vec += 2;
        if (bus.imem_req !== 1'b1) begin err++; $display("FAIL breq_req_held: got %b expected 1", bus.imem_req); end
        if (bus.imem_addr !== 8'h00) begin err++; $display("FAIL breq_addr_stable: got %h expected 00", bus.imem_addr); end
        wait_for(0, 1, 30, "breq_xfer");
        vec += 3;
        if (xq(0) !== 8'h40) begin err++; $display("FAIL breq_out_pc: got %h expected 40", xq(0)); end
        if (aq(0) !== 8'h00) begin err++; $display("FAIL breq_addr0: got %h expected 00", aq(0)); end
        if (aq(1) !== 8'h40) begin err++; $display("FAIL breq_addr1: got %h expected 40", aq(1)); end
    endtask

    task automatic test_branch_with_ack();
        apply_reset();
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(4, 0, 10, "back_ack");
        bv = 1'b1;
        bt = 8'h80;
        tick();
        bv = 1'b0;
        wait_for(0, 1, 30, "back_xfer");
        vec += 2;
        if (xq(0) !== 8'h80) begin err++; $display("FAIL bwack_out_pc: got %h expected 80", xq(0)); end
        if (aq(1) !== 8'h80) begin err++; $display("FAIL bwack_addr1: got %h expected 80", aq(1)); end
    endtask

    task automatic test_multi_branch();
        apply_reset();
        mem_lat = 4;
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(3, 0, 10, "multi_req");
        bv = 1'b1;
        bt = 8'h10;
        tick();
        bt = 8'h20;
        tick();
        bt = 8'h30;
        tick();
        bv = 1'b0;
        wait_for(0, 1, 40, "multi_xfer");
        vec += 2;
        if (xq(0) !== 8'h30) begin err++; $display("FAIL multi_out_pc: got %h expected 30", xq(0)); end
        if (aq(1) !== 8'h30) begin err++; $display("FAIL multi_addr1: got %h expected 30", aq(1)); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(2, 0, 20, "b2b_valid");
        bv = 1'b1;
        bt = 8'h20;
        tick();
        bv = 1'b0;
        wait_for(0, 2, 30, "b2b_xfer");
        vec += 3;
        if (xq(0) !== 8'h00) begin err++; $display("FAIL b2b_out_pc0: got %h expected 00", xq(0)); end
        if (xq(1) !== 8'h20) begin err++; $display("FAIL b2b_out_pc1: got %h expected 20", xq(1)); end
        if (aq(1) !== 8'h20) begin err++; $display("FAIL b2b_addr1: got %h expected 20", aq(1)); end
    endtask

    task automatic test_hold_branch();
        apply_reset();
        en = 1'b1;
        wait_for(2, 0, 20, "hold_valid");
        bv = 1'b1;
        bt = 8'h60;
        tick();
        bv = 1'b0;
        vec++;
        if (bus.out_valid !== 1'b0) begin err++; $display("FAIL hold_discard: got %b expected 0", bus.out_valid); end
        bus.out_ready = 1'b1;
        wait_for(0, 1, 30, "hold_xfer");
        vec++;
        if (xq(0) !== 8'h60) begin err++; $display("FAIL hold_out_pc: got %h expected 60", xq(0)); end
    endtask

    task automatic test_align();
        apply_reset();
        bv = 1'b1;
        bt = 8'h41;
        tick();
        bv = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        vec++;
        if (align_err !== 1'b1) begin err++; $display("FAIL align_pulse: got %b expected 1", align_err); end
        tick();
        vec++;
        if (align_err !== 1'b0) begin err++; $display("FAIL align_pulse_end: got %b expected 0", align_err); end
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(1, 1, 20, "align_ack");
        vec++;
        if (aq(0) !== 8'h00) begin err++; $display("FAIL align_pc_kept: got %h expected 00", aq(0)); end
`else
        vec++;
        if (align_err !== 1'b0) begin err++; $display("FAIL align_tied: got %b expected 0", align_err); end
        en = 1'b1;
        bus.out_ready = 1'b1;
        wait_for(1, 1, 20, "align_ack");
        vec++;
        if (aq(0) !== 8'h40) begin err++; $display("FAIL align_forced: got %h expected 40", aq(0)); end
`endif
    endtask

    task automatic test_reset_outstanding();
        apply_reset();
        mem_on = 1'b0;
        bv = 1'b1;
        bt = 8'h24;
        tick();
        bv = 1'b0;
        en = 1'b1;
        wait_for(3, 0, 10, "rst_out_req");
        vec++;
        if (bus.imem_addr !== 8'h24) begin err++; $display("FAIL rst_out_addr: got %h expected 24", bus.imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        vec += 3;
        if (bus.imem_req !== 1'b0) begin err++; $display("FAIL rst_out_req_drop: got %b expected 0", bus.imem_req); end
        if (bus.imem_addr !== 8'h00) begin err++; $display("FAIL rst_out_pc: got %h expected 00", bus.imem_addr); end
        if (state_dbg !== IDLE) begin err++; $display("FAIL rst_out_state: got %0d expected %0d", state_dbg, IDLE); end
        tick();
        en = 1'b0;
        rst_n = 1'b1;
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hDEAD;
        tick();
        bus.imem_ack = 1'b0;
        tick();
        vec += 3;
        if (state_dbg !== IDLE) begin err++; $display("FAIL late_ack_state: got %0d expected %0d", state_dbg, IDLE); end
        if (bus.out_valid !== 1'b0) begin err++; $display("FAIL late_ack_valid: got %b expected 0", bus.out_valid); end
        if (bus.out_instr !== 16'h0000) begin err++; $display("FAIL late_ack_instr: got %h expected 0000", bus.out_instr); end
        mem_on = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vec           = 0;
        err           = 0;
        mem_on        = 1'b1;
        mem_lat       = 2;
        en            = 1'b0;
        bv            = 1'b0;
        bt            = 8'h00;
        bus.out_ready = 1'b0;
        test_reset();
        test_sequential();
        test_wrap();
        test_stall();
        test_en_low_in_req();
        test_branch_in_req();
        test_branch_with_ack();
        test_multi_branch();
        test_back_to_back();
        test_hold_branch();
        test_align();
        test_reset_outstanding();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
